// File: rtl/sargantana_icache_mshr_unit.sv
// rtl/sargantana_icache_mshr_unit.sv - icache miss/refill unit
// Tracks up to N_MSHR line misses, assembles multi-beat refills, merges same-line misses, prefetches next line.
module sargantana_icache_mshr_unit #(
  parameter int PADDR_WIDTH = 40,
  parameter int LINE_WIDTH  = 256,
  parameter int BEAT_WIDTH  = 128,
  parameter int N_MSHR      = 2,
  parameter int WAY_W       = 2,
  parameter int PREFETCH_EN = 1,
  parameter int ID_W        = (N_MSHR > 1) ? $clog2(N_MSHR) : 1
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   miss_valid_i,
  input  logic [PADDR_WIDTH-1:0] miss_paddr_i,
  input  logic [WAY_W-1:0]       miss_way_i,
  input  logic                   miss_kill_i,
  output logic                   miss_ready_o,
  output logic                   miss_merge_o,
  output logic                   ifill_req_valid_o,
  output logic [PADDR_WIDTH-1:0] ifill_req_paddr_o,
  output logic [ID_W-1:0]        ifill_req_id_o,
  input  logic                   ifill_req_ready_i,
  input  logic                   ifill_resp_valid_i,
  input  logic [ID_W-1:0]        ifill_resp_id_i,
  input  logic [BEAT_WIDTH-1:0]  ifill_resp_data_i,
  output logic                   fill_valid_o,
  output logic [PADDR_WIDTH-1:0] fill_paddr_o,
  output logic [WAY_W-1:0]       fill_way_o,
  output logic [LINE_WIDTH-1:0]  fill_data_o,
  output logic                   fill_prefetch_o
);

  localparam int BEATS   = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W   = $clog2(LINE_WIDTH / 8);
  localparam int LINE_AW = PADDR_WIDTH - OFF_W;
  localparam int PAGE_LW = 12 - OFF_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q [N_MSHR];
  state_e              state_d [N_MSHR];
  logic [LINE_AW-1:0]  line_q  [N_MSHR];
  logic [WAY_W-1:0]    way_q   [N_MSHR];
  logic [CNT_W-1:0]    cnt_q   [N_MSHR];
  logic [LINE_WIDTH-1:0] data_q [N_MSHR];
  logic [N_MSHR-1:0]   pf_q;
  logic [N_MSHR-1:0]   killed_q;
  logic [N_MSHR-1:0]   lock_oh_q;

  logic [N_MSHR-1:0]   idle_vec, req_vec, done_vec, hit_dem, hit_pf, beat_hit;
  logic [N_MSHR-1:0]   dem_oh, pf_oh, alloc_dem_oh, alloc_pf_oh, grant_oh, fill_oh;
  logic                kill, miss_accept, alloc_dem, alloc_pf, same_page, req_fire;
  logic                found_d, found_p, found_g;
  logic [LINE_AW-1:0]  miss_line, next_line, req_line, fill_line;
  logic [OFF_W-1:0]    unused_offset;

  assign kill          = flush_i | miss_kill_i;
  assign miss_line     = miss_paddr_i[PADDR_WIDTH-1:OFF_W];
  assign next_line     = miss_line + LINE_AW'(1);
  assign unused_offset = miss_paddr_i[OFF_W-1:0];
  // Next line stays in the 4 KiB page unless this is the page's last line.
  assign same_page     = (miss_line[PAGE_LW-1:0] != {PAGE_LW{1'b1}});

  always_comb begin
    idle_vec = '0;
    req_vec  = '0;
    done_vec = '0;
    hit_dem  = '0;
    hit_pf   = '0;
    beat_hit = '0;
    for (int i = 0; i < N_MSHR; i++) begin
      idle_vec[i] = (state_q[i] == S_IDLE);
      req_vec[i]  = (state_q[i] == S_REQ);
      done_vec[i] = (state_q[i] == S_DONE) && !killed_q[i];
      hit_dem[i]  = !idle_vec[i] && !killed_q[i] && (line_q[i] == miss_line);
      hit_pf[i]   = !idle_vec[i] && !killed_q[i] && (line_q[i] == next_line);
      beat_hit[i] = ifill_resp_valid_i && (state_q[i] == S_WAIT) &&
                    (ifill_resp_id_i == ID_W'(i));
    end
  end

  assign miss_ready_o = |idle_vec;
  assign miss_accept  = miss_valid_i && miss_ready_o && !kill;
  assign miss_merge_o = miss_accept && (|hit_dem);
  assign alloc_dem    = miss_accept && !(|hit_dem);

  // Demand takes the lowest IDLE entry, the prefetch the next IDLE one.
  always_comb begin
    dem_oh  = '0;
    pf_oh   = '0;
    found_d = 1'b0;
    found_p = 1'b0;
    for (int i = 0; i < N_MSHR; i++) begin
      if (idle_vec[i]) begin
        if (!found_d) begin
          dem_oh[i] = 1'b1;
          found_d   = 1'b1;
        end else if (!found_p) begin
          pf_oh[i] = 1'b1;
          found_p  = 1'b1;
        end
      end
    end
  end

  assign alloc_pf     = (PREFETCH_EN != 0) && alloc_dem && found_p && same_page && !(|hit_pf);
  assign alloc_dem_oh = alloc_dem ? dem_oh : '0;
  assign alloc_pf_oh  = alloc_pf ? pf_oh : '0;

  // A stalled request keeps the grant so address/id stay stable until accepted.
  always_comb begin
    grant_oh = '0;
    found_g  = 1'b0;
    if (|(lock_oh_q & req_vec)) begin
      grant_oh = lock_oh_q & req_vec;
    end else begin
      for (int i = 0; i < N_MSHR; i++) begin
        if (!found_g && req_vec[i] && !pf_q[i]) begin
          grant_oh[i] = 1'b1;
          found_g     = 1'b1;
        end
      end
      for (int i = 0; i < N_MSHR; i++) begin
        if (!found_g && req_vec[i] && pf_q[i]) begin
          grant_oh[i] = 1'b1;
          found_g     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ifill_req_id_o = '0;
    req_line       = '0;
    for (int i = 0; i < N_MSHR; i++) begin
      if (grant_oh[i]) begin
        ifill_req_id_o = ID_W'(i);
        req_line       = line_q[i];
      end
    end
  end

  assign ifill_req_valid_o = |grant_oh;
  assign ifill_req_paddr_o = {req_line, {OFF_W{1'b0}}};
  assign req_fire          = ifill_req_valid_o && ifill_req_ready_i;

  always_comb begin
    fill_oh         = '0;
    fill_line       = '0;
    fill_way_o      = '0;
    fill_data_o     = '0;
    fill_prefetch_o = 1'b0;
    for (int i = N_MSHR - 1; i >= 0; i--) begin
      if (done_vec[i]) begin
        fill_oh         = '0;
        fill_oh[i]      = 1'b1;
        fill_line       = line_q[i];
        fill_way_o      = way_q[i];
        fill_data_o     = data_q[i];
        fill_prefetch_o = pf_q[i];
      end
    end
  end

  assign fill_valid_o = |fill_oh;
  assign fill_paddr_o = {fill_line, {OFF_W{1'b0}}};

  always_comb begin
    for (int i = 0; i < N_MSHR; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE: if (alloc_dem_oh[i] || alloc_pf_oh[i]) state_d[i] = S_REQ;
        S_REQ: begin
          if (kill) state_d[i] = S_IDLE;
          else if (req_fire && grant_oh[i]) state_d[i] = S_WAIT;
        end
        S_WAIT: if (beat_hit[i] && (cnt_q[i] == LAST_BEAT)) state_d[i] = S_DONE;
        S_DONE: state_d[i] = S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_oh_q <= '0;
      pf_q      <= '0;
      killed_q  <= '0;
      for (int i = 0; i < N_MSHR; i++) begin
        state_q[i] <= S_IDLE;
        line_q[i]  <= '0;
        way_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      lock_oh_q <= (ifill_req_valid_o && !ifill_req_ready_i) ? grant_oh : '0;
      for (int i = 0; i < N_MSHR; i++) begin
        state_q[i] <= state_d[i];
        if (alloc_dem_oh[i] || alloc_pf_oh[i]) begin
          line_q[i]   <= alloc_pf_oh[i] ? next_line : miss_line;
          way_q[i]    <= miss_way_i;
          pf_q[i]     <= alloc_pf_oh[i];
          killed_q[i] <= 1'b0;
          cnt_q[i]    <= '0;
        end
        // In-flight entries keep draining beats but must not fill the arrays.
        if (kill && (state_q[i] == S_WAIT)) killed_q[i] <= 1'b1;
        if (beat_hit[i]) cnt_q[i] <= (cnt_q[i] == LAST_BEAT) ? '0 : cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_MSHR; i++) begin
      if (beat_hit[i]) data_q[i][cnt_q[i]*BEAT_WIDTH +: BEAT_WIDTH] <= ifill_resp_data_i;
    end
  end

endmodule

// File: tb/tb_sargantana_icache_mshr_unit.sv
// tb/tb_sargantana_icache_mshr_unit.sv - scoreboard bench for sargantana_icache_mshr_unit
module tb_sargantana_icache_mshr_unit;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         flush_i, miss_valid_i, miss_kill_i;
  logic [39:0]  miss_paddr_i;
  logic [1:0]   miss_way_i;
  logic         miss_ready_o, miss_merge_o;
  logic         ifill_req_valid_o, ifill_req_ready_i;
  logic [39:0]  ifill_req_paddr_o;
  logic [0:0]   ifill_req_id_o;
  logic         ifill_resp_valid_i;
  logic [0:0]   ifill_resp_id_i;
  logic [127:0] ifill_resp_data_i;
  logic         fill_valid_o, fill_prefetch_o;
  logic [39:0]  fill_paddr_o;
  logic [1:0]   fill_way_o;
  logic [255:0] fill_data_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [39:0] paddr;
    logic [0:0]  id;
  } req_t;

  typedef struct packed {
    logic [39:0]  paddr;
    logic [1:0]   way;
    logic [255:0] data;
    logic         pf;
  } fill_t;

  req_t  req_q[$];
  fill_t fill_q[$];
  req_t  exp_r;
  fill_t exp_f;
  logic  merged, rdy;

  sargantana_icache_mshr_unit dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .miss_valid_i(miss_valid_i), .miss_paddr_i(miss_paddr_i), .miss_way_i(miss_way_i),
    .miss_kill_i(miss_kill_i), .miss_ready_o(miss_ready_o), .miss_merge_o(miss_merge_o),
    .ifill_req_valid_o(ifill_req_valid_o), .ifill_req_paddr_o(ifill_req_paddr_o),
    .ifill_req_id_o(ifill_req_id_o), .ifill_req_ready_i(ifill_req_ready_i),
    .ifill_resp_valid_i(ifill_resp_valid_i), .ifill_resp_id_i(ifill_resp_id_i),
    .ifill_resp_data_i(ifill_resp_data_i), .fill_valid_o(fill_valid_o),
    .fill_paddr_o(fill_paddr_o), .fill_way_o(fill_way_o), .fill_data_o(fill_data_o),
    .fill_prefetch_o(fill_prefetch_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted request and every fill pulse must match the head of its queue.
  always @(negedge clk_i) begin
    if (rstn_i === 1'b1) begin
      if (ifill_req_valid_o && ifill_req_ready_i) begin
        tests++;
        if (req_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_req: got paddr %0h id %0d expected none", ifill_req_paddr_o, ifill_req_id_o);
        end else begin
          exp_r = req_q.pop_front();
          if (ifill_req_paddr_o !== exp_r.paddr || ifill_req_id_o !== exp_r.id) begin
            fails++;
            $display("FAIL req: got paddr %0h id %0d expected paddr %0h id %0d",
                     ifill_req_paddr_o, ifill_req_id_o, exp_r.paddr, exp_r.id);
          end
        end
      end
      if (fill_valid_o) begin
        tests++;
        if (fill_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_fill: got paddr %0h expected none", fill_paddr_o);
        end else begin
          exp_f = fill_q.pop_front();
          if (fill_paddr_o !== exp_f.paddr || fill_way_o !== exp_f.way ||
              fill_data_o !== exp_f.data || fill_prefetch_o !== exp_f.pf) begin
            fails++;
            $display("FAIL fill: got paddr %0h way %0d pf %0d data %0h expected paddr %0h way %0d pf %0d data %0h",
                     fill_paddr_o, fill_way_o, fill_prefetch_o, fill_data_o,
                     exp_f.paddr, exp_f.way, exp_f.pf, exp_f.data);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_miss(input logic [39:0] a, input logic [1:0] w, output logic m, output logic r);
    miss_valid_i = 1'b1;
    miss_paddr_i = a;
    miss_way_i   = w;
    @(negedge clk_i);
    m = miss_merge_o;
    r = miss_ready_o;
    @(posedge clk_i);
    #1;
    miss_valid_i = 1'b0;
  endtask

  task automatic beat(input logic [0:0] id, input logic [127:0] d);
    ifill_resp_valid_i = 1'b1;
    ifill_resp_id_i    = id;
    ifill_resp_data_i  = d;
    @(posedge clk_i);
    #1;
    ifill_resp_valid_i = 1'b0;
  endtask

  task automatic push_req(input logic [39:0] a, input logic [0:0] id);
    req_t r;
    r.paddr = a;
    r.id    = id;
    req_q.push_back(r);
  endtask

  task automatic push_fill(input logic [39:0] a, input logic [1:0] w,
                           input logic [127:0] b1, input logic [127:0] b0, input logic pf);
    fill_t f;
    f.paddr = a;
    f.way   = w;
    f.data  = {b1, b0};
    f.pf    = pf;
    fill_q.push_back(f);
  endtask

  initial begin
    rstn_i = 1'b0; flush_i = 1'b0; miss_valid_i = 1'b0; miss_kill_i = 1'b0;
    miss_paddr_i = '0; miss_way_i = '0; ifill_req_ready_i = 1'b1;
    ifill_resp_valid_i = 1'b0; ifill_resp_id_i = '0; ifill_resp_data_i = '0;
    tick(2);
    @(negedge clk_i);
    check("reset_ready", miss_ready_o, 1);
    check("reset_req_valid", ifill_req_valid_o, 0);
    check("reset_fill_valid", fill_valid_o, 0);
    check("reset_merge", miss_merge_o, 0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    tick(1);

    // Demand + next-line prefetch, prefetch refill, merge, demand refill
    push_req(40'h00_8000_0040, 1'b0);
    push_req(40'h00_8000_0060, 1'b1);
    do_miss(40'h00_8000_0040, 2'd1, merged, rdy);
    check("t1_alloc_no_merge", merged, 0);
    tick(3);
    push_fill(40'h00_8000_0060, 2'd1, {4{32'h2222_0001}}, {4{32'h1111_0001}}, 1'b1);
    beat(1'b1, {4{32'h1111_0001}});
    beat(1'b1, {4{32'h2222_0001}});
    @(negedge clk_i);
    check("t1_pf_fill_pulse", fill_valid_o, 1);
    tick(1);
    do_miss(40'h00_8000_005C, 2'd3, merged, rdy);
    check("t3_merge", merged, 1);
    check("t3_ready", rdy, 1);
    tick(2);
    push_fill(40'h00_8000_0040, 2'd1, {4{32'hBBBB_0000}}, {4{32'hAAAA_0000}}, 1'b0);
    beat(1'b0, {4{32'hAAAA_0000}});
    @(negedge clk_i);
    check("t1_no_fill_after_beat0", fill_valid_o, 0);
    @(posedge clk_i); #1;
    beat(1'b0, {4{32'hBBBB_0000}});
    @(negedge clk_i);
    check("t1_fill_latency", fill_valid_o, 1);
    tick(1);
    @(negedge clk_i);
    check("t1_fill_one_cycle", fill_valid_o, 0);
    tick(1);

    // Page-crossing miss: no prefetch
    push_req(40'h00_8000_0FE0, 1'b0);
    do_miss(40'h00_8000_0FE0, 2'd2, merged, rdy);
    tick(2);
    @(negedge clk_i);
    check("t2_id1_idle", miss_ready_o, 1);
    push_fill(40'h00_8000_0FE0, 2'd2, {4{32'h0FE0_0002}}, {4{32'h0FE0_0001}}, 1'b0);
    beat(1'b0, {4{32'h0FE0_0001}});
    beat(1'b0, {4{32'h0FE0_0002}});
    tick(2);

    // Stalled request killed
    ifill_req_ready_i = 1'b0;
    do_miss(40'h00_8000_2000, 2'd0, merged, rdy);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("t4_stall_valid", ifill_req_valid_o, 1);
      check("t4_stall_paddr", ifill_req_paddr_o, 40'h00_8000_2000);
      tick(1);
    end
    check("t4_all_busy", miss_ready_o, 0);
    miss_kill_i = 1'b1;
    tick(1);
    miss_kill_i = 1'b0;
    @(negedge clk_i);
    check("t4_req_dropped", ifill_req_valid_o, 0);
    check("t4_entries_idle", miss_ready_o, 1);
    ifill_req_ready_i = 1'b1;
    tick(3);

    // Kill in WAIT: beats consumed without fill; killed line never merges
    push_req(40'h00_8000_3000, 1'b0);
    push_req(40'h00_8000_3020, 1'b1);
    do_miss(40'h00_8000_3000, 2'd3, merged, rdy);
    tick(3);
    miss_kill_i = 1'b1;
    tick(1);
    miss_kill_i = 1'b0;
    beat(1'b0, {4{32'h3000_0001}});
    beat(1'b0, {4{32'h3000_0002}});
    @(negedge clk_i);
    check("t5_killed_no_fill", fill_valid_o, 0);
    tick(1);
    @(negedge clk_i);
    check("t5_entry_free", miss_ready_o, 1);
    push_req(40'h00_8000_3020, 1'b0);
    do_miss(40'h00_8000_3020, 2'd0, merged, rdy);
    check("t5_killed_no_merge", merged, 0);
    tick(2);
    beat(1'b1, {4{32'h3020_0001}});
    beat(1'b1, {4{32'h3020_0002}});
    tick(1);
    push_fill(40'h00_8000_3020, 2'd0, {4{32'h3020_00B1}}, {4{32'h3020_00B0}}, 1'b0);
    beat(1'b0, {4{32'h3020_00B0}});
    beat(1'b0, {4{32'h3020_00B1}});
    tick(2);

    // Beat to IDLE entry ignored; all busy; reset mid-refill
    beat(1'b1, {4{32'hDEAD_BEEF}});
    tick(1);
    push_req(40'h00_8000_4000, 1'b0);
    push_req(40'h00_8000_4020, 1'b1);
    do_miss(40'h00_8000_4000, 2'd2, merged, rdy);
    tick(2);
    @(negedge clk_i);
    check("t6_all_busy", miss_ready_o, 0);
    tick(1);
    do_miss(40'h00_8000_4020, 2'd1, merged, rdy);
    check("t6_busy_no_merge", merged, 0);
    push_fill(40'h00_8000_4020, 2'd2, {4{32'h4020_0002}}, {4{32'h4020_0001}}, 1'b1);
    beat(1'b1, {4{32'h4020_0001}});
    beat(1'b1, {4{32'h4020_0002}});
    tick(1);
    beat(1'b0, {4{32'h4000_0001}});
    #2;
    rstn_i = 1'b0;
    #1;
    check("t6_rst_req_valid", ifill_req_valid_o, 0);
    check("t6_rst_req_paddr", ifill_req_paddr_o, 0);
    check("t6_rst_fill_valid", fill_valid_o, 0);
    check("t6_rst_fill_data", fill_data_o, 0);
    check("t6_rst_ready", miss_ready_o, 1);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    beat(1'b0, {4{32'h4000_0002}});
    @(negedge clk_i);
    check("t6_late_beat_no_fill", fill_valid_o, 0);
    tick(3);

    check("req_queue_drained", req_q.size(), 0);
    check("fill_queue_drained", fill_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
